antialias_reorderer: RTL and testbench

Collects the scrambled butterfly outputs of the MP3 `antialias` stage, where each cycle delivers one (x, y) sample pair per channel at arbitrary granule positions, into a 576-entry granule buffer. Once every position 0..575 has been written, it streams both channels out in natural index order, one sample per cycle. It sits between `antialias` and the IMDCT stage in the Layer III decode pipeline.

---
 rtl/mp3_pkg.sv | 16 +
 rtl/aa_sample_bank.sv | 46 ++++
 rtl/antialias_reorderer.sv | 137 +++++++++++++
 tb/tb_antialias_reorderer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pkg.sv
// Shared constants and types for the Layer III decode pipeline.
// The reorderer and its sample banks take their defaults from here.
package mp3_pkg;

    localparam int N_SAMPLES = 576;
    localparam int SAMPLE_W  = 32;
    localparam int POS_W     = 10;

    typedef logic signed [31:0] sample_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/aa_sample_bank.sv
// One channel of granule storage: two write ports (x, y) and one registered read port.
// The read register clears to zero whenever no read is requested.
module aa_sample_bank #(
    parameter int N_SAMPLES = 576,
    parameter int DW        = 32,
    parameter int PW        = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_we,
    input  logic [PW-1:0]        x_addr,
    input  logic signed [DW-1:0] x_data,
    input  logic                 y_we,
    input  logic [PW-1:0]        y_addr,
    input  logic signed [DW-1:0] y_data,
    input  logic                 rd_en,
    input  logic [PW-1:0]        rd_addr,
    output logic signed [DW-1:0] rd_data
);

    logic signed [DW-1:0] mem [N_SAMPLES];
    logic signed [DW-1:0] rd_data_reg;

    // The y write is issued last, so on an address collision y overwrites x.
    always_ff @(posedge clk) begin
        if (x_we) begin
            mem[x_addr] <= x_data;
        end
        if (y_we) begin
            mem[y_addr] <= y_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end else begin
            rd_data_reg <= '0;
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/antialias_reorderer.sv
// Gathers scrambled antialias butterfly outputs into a granule buffer, then
// streams both channels out in natural index order once every position is written.
module antialias_reorderer
    import mp3_pkg::state_t;
    import mp3_pkg::FILL;
    import mp3_pkg::DRAIN;
#(
    parameter int N_SAMPLES = mp3_pkg::N_SAMPLES,
    parameter int DW        = mp3_pkg::SAMPLE_W,
    parameter int PW        = mp3_pkg::POS_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        ch1_x_in,
    input  logic [DW-1:0]        ch1_y_in,
    input  logic [DW-1:0]        ch2_x_in,
    input  logic [DW-1:0]        ch2_y_in,
    input  logic [PW-1:0]        x_pos_in,
    input  logic [PW-1:0]        y_pos_in,
    input  logic                 valid_in,
    output logic signed [DW-1:0] ch1_out,
    output logic signed [DW-1:0] ch2_out,
    output logic                 valid_out
);

    localparam logic [PW-1:0] LAST_IDX  = PW'(N_SAMPLES - 1);
    localparam logic [PW-1:0] POS_LIMIT = PW'(N_SAMPLES);

    state_t               state_reg, state_next;
    logic [PW-1:0]        idx_reg, idx_next;
    logic [N_SAMPLES-1:0] flags_reg, flags_next;
    logic [N_SAMPLES-1:0] flag_hit;
    logic [N_SAMPLES-1:0] flags_merged;
    logic                 valid_out_reg;
    logic                 fill_write;
    logic                 x_we;
    logic                 y_we;
    logic                 rd_en;

    // Writes only land while filling; out-of-range positions touch neither data nor flags.
    assign fill_write = valid_in && (state_reg == FILL);
    assign x_we       = fill_write && (x_pos_in < POS_LIMIT);
    assign y_we       = fill_write && (y_pos_in < POS_LIMIT);
    assign rd_en      = (state_reg == DRAIN);

    generate
        for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_flag_hit
            assign flag_hit[gi] = (x_we && (x_pos_in == PW'(gi)))
                               || (y_we && (y_pos_in == PW'(gi)));
        end
    endgenerate

    assign flags_merged = flags_reg | flag_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FILL;
            idx_reg       <= '0;
            flags_reg     <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            flags_reg     <= flags_next;
            valid_out_reg <= (state_reg == DRAIN);
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        flags_next = flags_reg;
        case (state_reg)
            FILL: begin
                flags_next = flags_merged;
                // The completing write itself can trigger the drain on the same edge.
                if (&flags_merged) begin
                    state_next = DRAIN;
                    idx_next   = '0;
                end
            end
            DRAIN: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = FILL;
                    idx_next   = '0;
                    flags_next = '0;
                end else begin
                    idx_next = idx_reg + PW'(1);
                end
            end
            default: begin
                state_next = FILL;
                idx_next   = '0;
                flags_next = '0;
            end
        endcase
    end

    aa_sample_bank #(
        .N_SAMPLES (N_SAMPLES),
        .DW        (DW),
        .PW        (PW)
    ) u_bank_ch1 (
        .clk     (clk),
        .rst     (rst),
        .x_we    (x_we),
        .x_addr  (x_pos_in),
        .x_data  (ch1_x_in),
        .y_we    (y_we),
        .y_addr  (y_pos_in),
        .y_data  (ch1_y_in),
        .rd_en   (rd_en),
        .rd_addr (idx_reg),
        .rd_data (ch1_out)
    );

    aa_sample_bank #(
        .N_SAMPLES (N_SAMPLES),
        .DW        (DW),
        .PW        (PW)
    ) u_bank_ch2 (
        .clk     (clk),
        .rst     (rst),
        .x_we    (x_we),
        .x_addr  (x_pos_in),
        .x_data  (ch2_x_in),
        .y_we    (y_we),
        .y_addr  (y_pos_in),
        .y_data  (ch2_y_in),
        .rd_en   (rd_en),
        .rd_addr (idx_reg),
        .rd_data (ch2_out)
    );

    assign valid_out = valid_out_reg;

endmodule

// File: tb/tb_antialias_reorderer.sv
// Self-checking bench for antialias_reorderer: a granule-level model (plain arrays
// updated by write rules) predicts the natural-order drain of each granule.
module tb_antialias_reorderer;

    localparam int N = 576;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        ch1_x_in = '0;
    logic [31:0]        ch1_y_in = '0;
    logic [31:0]        ch2_x_in = '0;
    logic [31:0]        ch2_y_in = '0;
    logic [9:0]         x_pos_in = '0;
    logic [9:0]         y_pos_in = '0;
    logic               valid_in = 1'b0;
    logic signed [31:0] ch1_out;
    logic signed [31:0] ch2_out;
    logic               valid_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp1 [N];
    logic [31:0] exp2 [N];
    logic [31:0] got1 [N];
    logic [31:0] got2 [N];

    antialias_reorderer dut (
        .clk       (clk),
        .rst       (rst),
        .ch1_x_in  (ch1_x_in),
        .ch1_y_in  (ch1_y_in),
        .ch2_x_in  (ch2_x_in),
        .ch2_y_in  (ch2_y_in),
        .x_pos_in  (x_pos_in),
        .y_pos_in  (y_pos_in),
        .valid_in  (valid_in),
        .ch1_out   (ch1_out),
        .ch2_out   (ch2_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    // Drive one pair for one edge and apply the granule write rules to the model.
    task automatic write_pair(input int xp, input int yp,
                              input logic [31:0] x1, input logic [31:0] y1,
                              input logic [31:0] x2, input logic [31:0] y2);
        ch1_x_in = x1; ch1_y_in = y1; ch2_x_in = x2; ch2_y_in = y2;
        x_pos_in = xp[9:0]; y_pos_in = yp[9:0]; valid_in = 1'b1;
        if (xp < N) begin exp1[xp] = x1; exp2[xp] = x2; end
        if (yp < N) begin exp1[yp] = y1; exp2[yp] = y2; end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    // Wait (bounded) for valid_out, then capture the contiguous valid run.
    task automatic collect(input int budget, output int latency, output int count);
        latency = -1;
        count = 0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (valid_out) begin latency = c; break; end
        end
        if (latency < 0) return;
        while (valid_out && count < 700) begin
            if (count < N) begin got1[count] = ch1_out; got2[count] = ch2_out; end
            count++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || ch1_out !== 32'sd0 || ch2_out !== 32'sd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b ch1=%h ch2=%h expected 0/0/0", valid_out, ch1_out, ch2_out);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: got %b expected 0", valid_out);
        end
        $display("test_reset done");
    endtask

    task automatic test_identity();
        int lat, cnt;
        for (int k = 0; k < N / 2; k++)
            write_pair(2 * k, 2 * k + 1, 32'(2 * k), 32'(2 * k + 1), 32'(2 * k), 32'(2 * k + 1));
        collect(20, lat, cnt);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL identity_latency: got %0d expected 1", lat); end
        checks++;
        if (cnt !== N) begin errors++; $display("FAIL identity_count: got %0d expected %0d", cnt, N); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got1[i] !== 32'(i) || got2[i] !== 32'(i)) begin
                errors++;
                $display("FAIL identity_data[%0d]: got %h/%h expected %h", i, got1[i], got2[i], 32'(i));
            end
        end
        $display("granule identity drained: %0d samples, latency %0d", cnt, lat);
    endtask

    task automatic test_antialias();
        logic [31:0] vec1 [N];
        logic [31:0] vec2 [N];
        bit covered [N];
        int rest [$];
        int lat, cnt, half;
        for (int i = 0; i < N; i++) begin
            vec1[i] = $urandom;
            vec2[i] = $urandom;
            covered[i] = 1'b0;
        end
        vec1[0] = 32'h001879cd; vec1[1] = 32'h000e411f; vec1[2] = 32'h0; vec1[3] = 32'hfff1bee1;
        for (int sb = 1; sb < 32; sb++)
            for (int i = 0; i < 8; i++) begin
                covered[18 * sb - 1 - i] = 1'b1;
                covered[18 * sb + i] = 1'b1;
            end
        for (int i = 0; i < N; i++) if (!covered[i]) rest.push_back(i);
        half = rest.size() / 2;
        for (int j = 0; j + 1 < half; j += 2)
            write_pair(rest[j], rest[j + 1], vec1[rest[j]], vec1[rest[j + 1]], vec2[rest[j]], vec2[rest[j + 1]]);
        for (int sb = 1; sb < 32; sb++)
            for (int i = 0; i < 8; i++) begin
                int xp = 18 * sb - 1 - i;
                int yp = 18 * sb + i;
                write_pair(xp, yp, vec1[xp], vec1[yp], vec2[xp], vec2[yp]);
            end
        for (int j = (half / 2) * 2; j + 1 < rest.size(); j += 2)
            write_pair(rest[j], rest[j + 1], vec1[rest[j]], vec1[rest[j + 1]], vec2[rest[j]], vec2[rest[j + 1]]);
        collect(20, lat, cnt);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL antialias_latency: got %0d expected 1", lat); end
        checks++;
        if (cnt !== N) begin errors++; $display("FAIL antialias_count: got %0d expected %0d", cnt, N); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got1[i] !== vec1[i] || got2[i] !== vec2[i]) begin
                errors++;
                $display("FAIL antialias_data[%0d]: got %h/%h expected %h/%h", i, got1[i], got2[i], vec1[i], vec2[i]);
            end
        end
        $display("granule antialias drained: %0d samples, latency %0d", cnt, lat);
    endtask

    task automatic test_incomplete();
        int lat, cnt, hits;
        hits = 0;
        for (int k = 0; k < 287; k++) begin
            write_pair(2 * k, 2 * k + 1, $urandom, $urandom, $urandom, $urandom);
            if (valid_out) hits++;
        end
        write_pair(574, 1000, $urandom, $urandom, $urandom, $urandom);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (valid_out) hits++;
        end
        checks++;
        if (hits !== 0) begin errors++; $display("FAIL incomplete_no_valid: got %0d valid cycles expected 0", hits); end
        write_pair(575, 575, $urandom, $urandom, $urandom, $urandom);
        collect(20, lat, cnt);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL incomplete_latency: got %0d expected 1", lat); end
        checks++;
        if (cnt !== N) begin errors++; $display("FAIL incomplete_count: got %0d expected %0d", cnt, N); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got1[i] !== exp1[i] || got2[i] !== exp2[i]) begin
                errors++;
                $display("FAIL incomplete_data[%0d]: got %h/%h expected %h/%h", i, got1[i], got2[i], exp1[i], exp2[i]);
            end
        end
        $display("granule incomplete drained: %0d samples, latency %0d", cnt, lat);
    endtask

    task automatic test_collision();
        int order [$];
        int lat, cnt, tmp, r;
        write_pair(7, 7, 32'h0000AAAA, 32'h00005555, 32'h0000AAAA, 32'h00005555);
        write_pair(600, 600, $urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < N; i++) if (i != 7) order.push_back(i);
        for (int i = order.size() - 1; i > 0; i--) begin
            r = $urandom_range(i, 0);
            tmp = order[i]; order[i] = order[r]; order[r] = tmp;
        end
        for (int j = 0; j < order.size(); j += 2) begin
            if (j + 1 < order.size())
                write_pair(order[j], order[j + 1], $urandom, $urandom, $urandom, $urandom);
            else
                write_pair(order[j], 600, $urandom, $urandom, $urandom, $urandom);
        end
        collect(20, lat, cnt);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL collision_latency: got %0d expected 1", lat); end
        checks++;
        if (got1[7] !== 32'h00005555 || got2[7] !== 32'h00005555) begin
            errors++;
            $display("FAIL collision_index7: got %h/%h expected 00005555", got1[7], got2[7]);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got1[i] !== exp1[i] || got2[i] !== exp2[i]) begin
                errors++;
                $display("FAIL collision_data[%0d]: got %h/%h expected %h/%h", i, got1[i], got2[i], exp1[i], exp2[i]);
            end
        end
        $display("granule collision drained: %0d samples, latency %0d", cnt, lat);
    endtask

    task automatic test_reset_drain();
        int lat, cnt, hits, seen;
        for (int k = 0; k < N / 2; k++)
            write_pair(2 * k, 2 * k + 1, $urandom, $urandom, $urandom, $urandom);
        seen = -1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (valid_out) begin seen = 0; break; end
        end
        while (seen >= 0 && seen < 100) begin
            @(posedge clk); #1;
            seen++;
        end
        checks++;
        if (valid_out !== 1'b1 || ch1_out !== exp1[100]) begin
            errors++;
            $display("FAIL reset_drain_idx100: got valid=%b ch1=%h expected 1/%h", valid_out, ch1_out, exp1[100]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0 || ch1_out !== 32'sd0) begin
            errors++;
            $display("FAIL reset_drain_drop: got valid=%b ch1=%h expected 0/0", valid_out, ch1_out);
        end
        #3 rst = 1'b0;
        hits = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (valid_out) hits++;
        end
        for (int k = 0; k < 150; k++) begin
            write_pair(2 * k, 2 * k + 1, $urandom, $urandom, $urandom, $urandom);
            if (valid_out) hits++;
        end
        checks++;
        if (hits !== 0) begin errors++; $display("FAIL reset_drain_quiet: got %0d valid cycles expected 0", hits); end
        for (int k = 150; k < N / 2; k++)
            write_pair(2 * k, 2 * k + 1, $urandom, $urandom, $urandom, $urandom);
        collect(20, lat, cnt);
        checks++;
        if (lat !== 1 || cnt !== N) begin
            errors++;
            $display("FAIL reset_drain_restart: got latency %0d count %0d expected 1/%0d", lat, cnt, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got1[i] !== exp1[i] || got2[i] !== exp2[i]) begin
                errors++;
                $display("FAIL reset_drain_data[%0d]: got %h/%h expected %h/%h", i, got1[i], got2[i], exp1[i], exp2[i]);
            end
        end
        $display("granule after reset drained: %0d samples, latency %0d", cnt, lat);
    endtask

    task automatic test_back_to_back();
        int lat, cnt, hits, start;
        for (int k = 0; k < N / 2; k++)
            write_pair(2 * k, 2 * k + 1, $urandom, $urandom, $urandom, $urandom);
        start = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (valid_out) begin start = c; break; end
        end
        cnt = 0;
        // Junk writes aimed at not-yet-read positions must be dropped during the drain.
        while (start > 0 && valid_out && cnt < N) begin
            got1[cnt] = ch1_out; got2[cnt] = ch2_out;
            cnt++;
            if (cnt == N) break;
            ch1_x_in = $urandom; ch1_y_in = $urandom; ch2_x_in = $urandom; ch2_y_in = $urandom;
            x_pos_in = 10'($urandom_range(N - 1, cnt));
            y_pos_in = 10'($urandom_range(N - 1, cnt));
            valid_in = 1'b1;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        checks++;
        if (start !== 1 || cnt !== N) begin
            errors++;
            $display("FAIL b2b_first: got latency %0d count %0d expected 1/%0d", start, cnt, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got1[i] !== exp1[i] || got2[i] !== exp2[i]) begin
                errors++;
                $display("FAIL b2b_first_data[%0d]: got %h/%h expected %h/%h", i, got1[i], got2[i], exp1[i], exp2[i]);
            end
        end
        $display("granule b2b first drained: %0d samples, latency %0d", cnt, start);
        hits = 0;
        for (int k = N / 2 - 1; k >= 0; k--) begin
            write_pair(2 * k + 1, 2 * k, $urandom, $urandom, $urandom, $urandom);
            if (valid_out) hits++;
        end
        checks++;
        if (hits !== 0) begin errors++; $display("FAIL b2b_second_quiet: got %0d valid cycles expected 0", hits); end
        collect(20, lat, cnt);
        checks++;
        if (lat !== 1 || cnt !== N) begin
            errors++;
            $display("FAIL b2b_second: got latency %0d count %0d expected 1/%0d", lat, cnt, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got1[i] !== exp1[i] || got2[i] !== exp2[i]) begin
                errors++;
                $display("FAIL b2b_second_data[%0d]: got %h/%h expected %h/%h", i, got1[i], got2[i], exp1[i], exp2[i]);
            end
        end
        $display("granule b2b second drained: %0d samples, latency %0d", cnt, lat);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_antialias();
        test_incomplete();
        test_collision();
        test_reset_drain();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
